// File: rtl/pacman_pkg.sv
// Shared types and screen constants for the Pacman movement controller.
// Holds direction/state enums, the request struct and the cursor priority encoder.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVING  = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic vld;
    dir_t dir;
  } req_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SCALE     = 4;
  localparam int SPRITE_PX = 16 * SCALE;

  // Sprite centred on screen at reset
  localparam logic [9:0] RST_X = 10'd288;
  localparam logic [9:0] RST_Y = 10'd208;

  function automatic req_t encode_cursor(input logic [3:0] c);
    req_t r;
    r.vld = 1'b1;
    r.dir = DIR_RIGHT;
    if (c[0])      r.dir = DIR_RIGHT;
    else if (c[1]) r.dir = DIR_LEFT;
    else if (c[2]) r.dir = DIR_UP;
    else if (c[3]) r.dir = DIR_DOWN;
    else           r.vld = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pacman_motion_if.sv
// Frame tick / buttons in, registered sprite position and animation state out.
// master drives the stimulus side, slave is the motion controller.
interface pacman_motion_if;
  import pacman_pkg::*;

  logic       frame_tick;
  logic [3:0] cursor;
  logic [9:0] pac_x;
  logic [9:0] pac_y;
  dir_t       direction;
  logic [1:0] frame_select;
  logic       moving;

  modport master (
    output frame_tick, cursor,
    input  pac_x, pac_y, direction, frame_select, moving
  );

  modport slave (
    input  frame_tick, cursor,
    output pac_x, pac_y, direction, frame_select, moving
  );
endinterface

// File: rtl/pacman_motion_dir_debounce.sv
// Priority-encodes the buttons and accepts a request seen on two consecutive frame ticks.
// accept is combinational in the tick cycle; the previous request updates on every tick.
module dir_debounce
  import pacman_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [3:0] cursor,
  output logic       accept,
  output dir_t       dir
);

  req_t req;
  req_t prev;

  always_comb req = encode_cursor(cursor);

  always_ff @(posedge clk) begin
    if (rst)             prev <= '0;
    else if (frame_tick) prev <= req;
  end

  assign accept = frame_tick && req.vld && prev.vld && (req.dir == prev.dir);
  assign dir    = req.dir;

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pacman motion: debounced direction, bounded position, animation frame select.
// Outputs update 1 clk after frame_tick, no backpressure; PACMAN_WRAP_EN enables horizontal tunnel wrap.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int STEP      = 2,
  parameter int SPRITE_PX = 16 * pacman_pkg::SCALE,
  parameter int ANIM_DIV  = 20
) (
  input  logic              clk,
  input  logic              rst,
  pacman_motion_if.slave    bus
);

  localparam logic [10:0] XMAX     = 11'(SCREEN_W - SPRITE_PX);
  localparam logic [10:0] YMAX     = 11'(SCREEN_H - SPRITE_PX);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [4:0]  ANIM_END = 5'(ANIM_DIV);

  state_t     state, state_nxt;
  logic [9:0] x_q, x_d, y_q, y_d;
  dir_t       dir_q, dir_d, acc_dir, cur_dir;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] fs_q, fs_d;
  logic       accept;
  logic       step_ok;
  logic [9:0] nx, ny;
  logic [10:0] x11, y11;

  dir_debounce u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (bus.frame_tick),
    .cursor     (bus.cursor),
    .accept     (accept),
    .dir        (acc_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      x_q   <= RST_X;
      y_q   <= RST_Y;
      dir_q <= DIR_RIGHT;
      cnt_q <= '0;
      fs_q  <= '0;
    end else begin
      state <= state_nxt;
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      fs_q  <= fs_d;
    end
  end

  always_comb begin
    state_nxt = state;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    fs_d      = fs_q;
    x11       = {1'b0, x_q};
    y11       = {1'b0, y_q};
    cur_dir   = accept ? acc_dir : dir_q;
    step_ok   = 1'b0;
    nx        = x_q;
    ny        = y_q;

    // Bounds are checked before stepping so the 10-bit position never wraps
    case (cur_dir)
      DIR_RIGHT: begin
        if (x11 + STEP11 <= XMAX) begin
          nx = 10'(x11 + STEP11); step_ok = 1'b1;
        end else begin
`ifdef PACMAN_WRAP_EN
          nx = '0; step_ok = 1'b1;
`else
          nx = 10'(XMAX);
`endif
        end
      end
      DIR_LEFT: begin
        if (x11 >= STEP11) begin
          nx = 10'(x11 - STEP11); step_ok = 1'b1;
        end else begin
`ifdef PACMAN_WRAP_EN
          nx = 10'(XMAX); step_ok = 1'b1;
`else
          nx = '0;
`endif
        end
      end
      DIR_UP: begin
        if (y11 >= STEP11) begin
          ny = 10'(y11 - STEP11); step_ok = 1'b1;
        end else begin
          ny = '0;
        end
      end
      default: begin
        if (y11 + STEP11 <= YMAX) begin
          ny = 10'(y11 + STEP11); step_ok = 1'b1;
        end else begin
          ny = 10'(YMAX);
        end
      end
    endcase

    if (bus.frame_tick && (state != ST_IDLE || accept)) begin
      dir_d     = cur_dir;
      x_d       = nx;
      y_d       = ny;
      state_nxt = step_ok ? ST_MOVING : ST_BLOCKED;
      if (step_ok) begin
        if (cnt_q + 5'd1 == ANIM_END) begin
          cnt_d = '0;
          fs_d  = fs_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    end
  end

  assign bus.pac_x        = x_q;
  assign bus.pac_y        = y_q;
  assign bus.direction    = dir_q;
  assign bus.frame_select = fs_q;
  assign bus.moving       = (state == ST_MOVING);

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion: debounce, priority, walls, animation, edge and reset behaviour.
module tb_pacman_motion;
  import pacman_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pacman_motion_if bus();

  pacman_motion #(.STEP(2), .SPRITE_PX(64), .ANIM_DIV(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #20 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.cursor = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  // n ticks on consecutive clock cycles
  task automatic tick_burst(input int n);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pac_x !== 10'd288) begin errors++; $display("FAIL reset_x got %0d want 288", bus.pac_x); end
    checks++; if (bus.pac_y !== 10'd208) begin errors++; $display("FAIL reset_y got %0d want 208", bus.pac_y); end
    checks++; if (bus.direction !== 2'd0) begin errors++; $display("FAIL reset_dir got %0d want 0", bus.direction); end
    checks++; if (bus.frame_select !== 2'd0) begin errors++; $display("FAIL reset_fs got %0d want 0", bus.frame_select); end
    checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL reset_moving got %0b want 0", bus.moving); end
  endtask

  task automatic test_right();
    do_reset();
    bus.cursor = 4'b0001;
    do_tick();
    checks++; if (bus.pac_x !== 10'd288 || bus.moving !== 1'b0) begin errors++; $display("FAIL right_t1 x=%0d mv=%0b want 288/0", bus.pac_x, bus.moving); end
    do_tick();
    checks++; if (bus.pac_x !== 10'd290 || bus.direction !== 2'd0) begin errors++; $display("FAIL right_t2 x=%0d dir=%0d want 290/0", bus.pac_x, bus.direction); end
    checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL right_mv got %0b want 1", bus.moving); end
    do_tick();
    checks++; if (bus.pac_x !== 10'd292) begin errors++; $display("FAIL right_t3 x=%0d want 292", bus.pac_x); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.cursor = 4'b0110;
    do_tick();
    do_tick();
    checks++; if (bus.direction !== 2'd1) begin errors++; $display("FAIL prio_dir got %0d want 1", bus.direction); end
    checks++; if (bus.pac_x !== 10'd286 || bus.pac_y !== 10'd208) begin errors++; $display("FAIL prio_pos x=%0d y=%0d want 286/208", bus.pac_x, bus.pac_y); end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.cursor = 4'b1000;
    do_tick();
    bus.cursor = 4'b0000;
    do_tick();
    checks++; if (bus.direction !== 2'd0 || bus.pac_y !== 10'd208 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL glitch dir=%0d y=%0d mv=%0b want 0/208/0", bus.direction, bus.pac_y, bus.moving); end
    bus.cursor = 4'b1000;
    do_tick();
    bus.cursor = 4'b0100;
    do_tick();
    checks++; if (bus.pac_y !== 10'd208 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL glitch_change y=%0d mv=%0b want 208/0", bus.pac_y, bus.moving); end
  endtask

  task automatic test_down_wall();
    do_reset();
    bus.cursor = 4'b1000;
    tick_burst(105);  // 1 debounce tick + 104 steps
    checks++; if (bus.pac_y !== 10'd416 || bus.moving !== 1'b1) begin errors++; $display("FAIL wall_reach y=%0d mv=%0b want 416/1", bus.pac_y, bus.moving); end
    checks++; if (bus.frame_select !== 2'd1) begin errors++; $display("FAIL wall_fs got %0d want 1", bus.frame_select); end
    tick_burst(3);
    checks++; if (bus.pac_y !== 10'd416 || bus.moving !== 1'b0) begin errors++; $display("FAIL wall_block y=%0d mv=%0b want 416/0", bus.pac_y, bus.moving); end
    checks++; if (bus.frame_select !== 2'd1) begin errors++; $display("FAIL wall_fs_hold got %0d want 1", bus.frame_select); end
    bus.cursor = 4'b0100;
    do_tick();
    checks++; if (bus.pac_y !== 10'd416 || bus.moving !== 1'b0) begin errors++; $display("FAIL wall_up1 y=%0d mv=%0b want 416/0", bus.pac_y, bus.moving); end
    do_tick();
    checks++; if (bus.pac_y !== 10'd414 || bus.moving !== 1'b1 || bus.direction !== 2'd2) begin
      errors++; $display("FAIL wall_up2 y=%0d mv=%0b dir=%0d want 414/1/2", bus.pac_y, bus.moving, bus.direction); end
  endtask

  task automatic test_anim();
    do_reset();
    bus.cursor = 4'b0001;
    tick_burst(20);  // 19 moving ticks
    checks++; if (bus.frame_select !== 2'd0) begin errors++; $display("FAIL anim_19 fs=%0d want 0", bus.frame_select); end
    do_tick();
    checks++; if (bus.frame_select !== 2'd1 || bus.pac_x !== 10'd328) begin errors++; $display("FAIL anim_20 fs=%0d x=%0d want 1/328", bus.frame_select, bus.pac_x); end
    tick_burst(19);
    checks++; if (bus.frame_select !== 2'd1) begin errors++; $display("FAIL anim_39 fs=%0d want 1", bus.frame_select); end
    do_tick();
    checks++; if (bus.frame_select !== 2'd2 || bus.pac_x !== 10'd368) begin errors++; $display("FAIL anim_40 fs=%0d x=%0d want 2/368", bus.frame_select, bus.pac_x); end
  endtask

  task automatic test_right_edge();
    logic [9:0] exp_x;
    logic       exp_mv;
`ifdef PACMAN_WRAP_EN
    exp_x = 10'd0;   exp_mv = 1'b1;
`else
    exp_x = 10'd576; exp_mv = 1'b0;
`endif
    do_reset();
    bus.cursor = 4'b0001;
    tick_burst(145);
    checks++; if (bus.pac_x !== 10'd576 || bus.moving !== 1'b1) begin errors++; $display("FAIL edge_reach x=%0d mv=%0b want 576/1", bus.pac_x, bus.moving); end
    do_tick();
    checks++; if (bus.pac_x !== exp_x || bus.moving !== exp_mv) begin errors++; $display("FAIL edge_step x=%0d mv=%0b want %0d/%0b", bus.pac_x, bus.moving, exp_x, exp_mv); end
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.frame_tick = 1'b0;
    checks++; if (bus.pac_x !== 10'd288 || bus.pac_y !== 10'd208 || bus.direction !== 2'd0 || bus.frame_select !== 2'd0 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL rst_tick x=%0d y=%0d dir=%0d fs=%0d mv=%0b want 288/208/0/0/0",
                         bus.pac_x, bus.pac_y, bus.direction, bus.frame_select, bus.moving); end
    do_tick();
    checks++; if (bus.pac_x !== 10'd288 || bus.moving !== 1'b0) begin errors++; $display("FAIL rst_prev x=%0d mv=%0b want 288/0", bus.pac_x, bus.moving); end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.cursor = 4'b0000;
    repeat (2) @(negedge clk);
    test_reset();
    test_right();
    test_priority();
    test_glitch();
    test_down_wall();
    test_anim();
    test_right_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
